// File: rtl/agv_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : agv_shift_ctrl
// Brief    : Serialises a gain word to an AGV (VGA gain) device over a
//            clock/data/latch port. Define AGV_LSB_FIRST_EN for LSB-first order.
// Revision : 1.0 - initial release
// ============================================================================
module agv_shift_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              CLK_IN,
    input  logic              RST_IN,
    input  logic [DATA_W-1:0] gain_data,
    input  logic              gain_valid,
    output logic              gain_ready,
    output logic              busy,
    output logic              done,
    output logic              AGV_DATA,
    output logic              AGV_CLK,
    output logic              AGV_LTCH
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LATCH    = 3'd3,
        ST_GAP      = 3'd4
    } state_t;

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] c_BIT_LAST = 6'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [7:0]        r_div_cnt;
    logic [5:0]        r_bit_cnt;
    logic              r_hold;
    logic              r_done;

    logic              w_div_end;
    logic              w_last_bit;
    logic              w_accept;
    logic              w_cur_bit;
    logic [DATA_W-1:0] w_shift_adv;

    assign w_div_end  = (r_div_cnt == c_DIV_LAST);
    assign w_last_bit = (r_bit_cnt == c_BIT_LAST);
    assign w_accept   = gain_valid && (r_state == ST_IDLE);

`ifdef AGV_LSB_FIRST_EN
    assign w_cur_bit   = r_shift[0];
    assign w_shift_adv = {1'b0, r_shift[DATA_W-1:1]};
`else
    assign w_cur_bit   = r_shift[DATA_W-1];
    assign w_shift_adv = {r_shift[DATA_W-2:0], 1'b0};
`endif

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gain_ready  = 1'b0;
        AGV_CLK     = 1'b0;
        AGV_LTCH    = 1'b0;
        AGV_DATA    = r_hold;
        case (r_state)
            ST_IDLE: begin
                gain_ready = 1'b1;
                if (gain_valid) begin
                    w_state_nxt = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                AGV_DATA = w_cur_bit;
                if (w_div_end) begin
                    w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                AGV_CLK  = 1'b1;
                AGV_DATA = w_cur_bit;
                if (w_div_end) begin
                    w_state_nxt = w_last_bit ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                AGV_LTCH = 1'b1;
                if (w_div_end) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_div_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // r_hold tracks the bit just clocked out so the data line keeps its
    // last value through LATCH, GAP and IDLE.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_hold    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == ST_GAP) && w_div_end;
            if (r_state == ST_IDLE) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                if (w_accept) begin
                    r_shift <= gain_data;
                end
            end else begin
                r_div_cnt <= w_div_end ? 8'd0 : r_div_cnt + 8'd1;
                if ((r_state == ST_SHIFT_HI) && w_div_end) begin
                    r_shift   <= w_shift_adv;
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    r_hold    <= w_cur_bit;
                end
            end
        end
    end

    assign busy = ~gain_ready;
    assign done = r_done;

endmodule
`default_nettype wire
